// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the parametrised SRAM and its
//               clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int addr_w,
                                     input int depth, input int rd_lat);
        return (data_w >= 8) && (data_w % 8 == 0) && (addr_w >= 1) &&
               (depth > 1) && (depth <= (1 << addr_w)) &&
               ((rd_lat == 1) || (rd_lat == 2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_clear_seq.sv
// ============================================================================
// Module      : mem_clear_seq
// Description : CLEAR/IDLE sequencer that walks a pointer over every word and
//               zeroes it after reset or on a clr request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             busy,
    output logic             clr_we,
    output logic [PTR_W-1:0] clr_addr
);

    localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);

    clr_state_t       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == c_last) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end
                end
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = (r_state == CLEAR);
    assign clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/mem_sram_param.sv
// ============================================================================
// Module      : mem_sram_param
// Description : Single-port register memory with byte-lane writes, 1 or 2
//               cycle read latency, selectable read-during-write and a
//               hardware clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_param
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 2 ** ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   Datain,
    output logic [DATA_W-1:0]   Dataout,
    output logic                rd_valid,
    output logic                busy,
    output logic                drop
);

    localparam int                c_be_w      = be_width(DATA_W);
    localparam int                c_ptr_w     = ptr_width(DEPTH);
    localparam logic [DATA_W-1:0] c_zero_word = '0;

    generate
        if (!params_ok(DATA_W, ADDR_W, DEPTH, RD_LAT)) begin : g_param_check
            $error("mem_sram_param: illegal DATA_W/ADDR_W/DEPTH/RD_LAT combination");
        end
    endgenerate

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               w_busy;
    logic               w_clr_we;
    logic [c_ptr_w-1:0] w_clr_addr;
    logic               w_in_range;
    logic [c_ptr_w-1:0] w_idx;
    logic               w_acc_wr;
    logic               w_acc_rd;
    logic [DATA_W-1:0]  w_old;
    logic [DATA_W-1:0]  w_merged;
    logic [DATA_W-1:0]  w_rd_data;
    logic [DATA_W-1:0]  r_dout;
    logic               r_rdv;
    logic               r_drop;

    mem_clear_seq #(
        .DEPTH (DEPTH),
        .PTR_W (c_ptr_w)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign w_in_range = 1'b1;
        end else begin : g_part_range
            assign w_in_range = (32'(addr) < 32'($unsigned(DEPTH)));
        end
    endgenerate

    assign w_idx    = addr[c_ptr_w-1:0];
    assign w_acc_wr = wr && !w_busy && w_in_range;
    assign w_acc_rd = rd && !w_busy;
    assign w_old    = r_mem[w_idx];

    generate
        for (genvar i = 0; i < c_be_w; i++) begin : g_lane
            assign w_merged[8*i +: 8] = be[i] ? Datain[8*i +: 8] : w_old[8*i +: 8];
        end
    endgenerate

    // Out-of-range reads still complete, returning zero.
    assign w_rd_data = !w_in_range                   ? c_zero_word :
                       ((WR_FIRST != 0) && w_acc_wr) ? w_merged    : w_old;

    // Sweep and user writes are exclusive: user writes need busy low.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= c_zero_word;
            end else if (w_acc_wr) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop <= 1'b0;
        end else if (w_busy) begin
            r_drop <= wr || rd || clr;
        end else begin
            r_drop <= (wr || rd) && !w_in_range;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s1_v;
            logic [DATA_W-1:0] r_s1_d;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_s1_v <= 1'b0;
                    r_s1_d <= c_zero_word;
                    r_rdv  <= 1'b0;
                    r_dout <= c_zero_word;
                end else begin
                    r_s1_v <= w_acc_rd;
                    if (w_acc_rd) begin
                        r_s1_d <= w_rd_data;
                    end
                    r_rdv <= r_s1_v;
                    if (r_s1_v) begin
                        r_dout <= r_s1_d;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rdv  <= 1'b0;
                    r_dout <= c_zero_word;
                end else begin
                    r_rdv <= w_acc_rd;
                    if (w_acc_rd) begin
                        r_dout <= w_rd_data;
                    end
                end
            end
        end
    endgenerate

    assign Dataout  = r_dout;
    assign rd_valid = r_rdv;
    assign busy     = w_busy;
    assign drop     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_param.sv
// ============================================================================
// Module      : tb_mem_sram_param
// Description : Self-checking bench for mem_sram_param: two configurations
//               driven in lockstep, table vectors, directed sequences and
//               random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sram_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, wr, rd;
    logic [3:0]  addr, be;
    logic [31:0] din;
    logic [7:0]  dout0;
    logic [31:0] dout1;
    logic        rdv0, rdv1, busy0, busy1, drop0, drop1;

    mem_sram_param #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .WR_FIRST(1)
    ) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .addr(addr),
        .be(be[0:0]), .Datain(din[7:0]), .Dataout(dout0),
        .rd_valid(rdv0), .busy(busy0), .drop(drop0)
    );

    mem_sram_param #(
        .DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .WR_FIRST(0)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .addr(addr),
        .be(be), .Datain(din), .Dataout(dout1),
        .rd_valid(rdv1), .busy(busy1), .drop(drop1)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: per configuration, a word array, a count of sweep
    // cycles still to run, and the visible outputs after each clock edge.
    int          m_dw    [2] = '{8, 32};
    int          m_depth [2] = '{16, 12};
    int          m_lat   [2] = '{1, 2};
    int          m_wf    [2] = '{1, 0};
    logic [31:0] m_mem   [2][16];
    int          m_left  [2];
    logic [31:0] m_dout  [2];
    logic        m_valid [2];
    logic        m_drop  [2];
    logic        m_pv    [2];
    logic [31:0] m_pd    [2];

    task automatic model_edge(input int k);
        logic [31:0] dmask, bmask, old, nw, rdata;
        logic        rv, dr, inr;
        dmask = (m_dw[k] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        if (!rst) begin
            m_dout[k]  = '0;
            m_valid[k] = 1'b0;
            m_drop[k]  = 1'b0;
            m_pv[k]    = 1'b0;
            m_left[k]  = m_depth[k];
            return;
        end
        rv    = 1'b0;
        rdata = '0;
        if (m_left[k] > 0) begin
            dr = wr | rd | clr;
            m_mem[k][m_depth[k] - m_left[k]] = '0;
            m_left[k]--;
        end else begin
            inr   = (int'(addr) < m_depth[k]);
            old   = inr ? m_mem[k][addr] : '0;
            bmask = '0;
            for (int i = 0; i < m_dw[k] / 8; i++)
                if (be[i]) bmask[8*i +: 8] = 8'hFF;
            nw = ((old & ~bmask) | (din & bmask)) & dmask;
            if (wr && inr) m_mem[k][addr] = nw;
            if (rd) begin
                rv    = 1'b1;
                rdata = !inr ? '0 : (wr && m_wf[k] == 1) ? nw : old;
            end
            dr = (wr | rd) && !inr;
            if (clr) m_left[k] = m_depth[k];
        end
        m_drop[k] = dr;
        if (m_lat[k] == 1) begin
            m_valid[k] = rv;
            if (rv) m_dout[k] = rdata;
        end else begin
            m_valid[k] = m_pv[k];
            if (m_pv[k]) m_dout[k] = m_pd[k];
            m_pv[k] = rv;
            m_pd[k] = rdata;
        end
    endtask

    task automatic check_model(input int k);
        logic [31:0] a_d;
        logic        a_v, a_b, a_dr, e_b;
        if (k == 0) begin
            a_d = {24'h0, dout0}; a_v = rdv0; a_b = busy0; a_dr = drop0;
        end else begin
            a_d = dout1; a_v = rdv1; a_b = busy1; a_dr = drop1;
        end
        e_b = (m_left[k] > 0);
        n_vec++;
        if ({a_b, a_dr, a_v, a_d} !== {e_b, m_drop[k], m_valid[k], m_dout[k]}) begin
            n_bad++;
            $display("FAIL model_dut%0d t=%0t busy/drop/valid/dout got %b/%b/%b/%h want %b/%b/%b/%h",
                     k, $time, a_b, a_dr, a_v, a_d, e_b, m_drop[k], m_valid[k], m_dout[k]);
        end
    endtask

    task automatic expect_eq(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic rr,
                        input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        rst = r; clr = c; wr = w; rd = rr; addr = a; be = b; din = d;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_model(0);
        check_model(1);
    endtask

    typedef struct {
        logic        wr, rd, clr;
        logic [3:0]  addr;
        logic [31:0] din;
        logic        e_busy, e_valid, e_drop;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Expected outputs of the 8-bit, RD_LAT=1, WR_FIRST=1 instance.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd1, 32'hAA, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd2, 32'hBB, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd1, 32'h00, 1'b0, 1'b1, 1'b0, 8'hAA};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd2, 32'h00, 1'b0, 1'b1, 1'b0, 8'hBB};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd0, 32'h00, 1'b0, 1'b0, 1'b0, 8'hBB};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4'd2, 32'hCC, 1'b0, 1'b1, 1'b0, 8'hCC};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 4'd2, 32'h00, 1'b0, 1'b1, 1'b0, 8'hCC};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 4'd3, 32'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 4'd1, 32'h55, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 4'd1, 32'h77, 1'b1, 1'b0, 1'b1, 8'h00};

        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 16; j++) m_mem[k][j] = '0;

        // Reset for 3 cycles, then the initial sweep of 16 words.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
            expect_eq("reset_state", {23'h0, busy0, rdv0, drop0, dout0}, {23'h0, 3'b100, 8'h00});
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
            expect_eq("init_sweep_busy", {32'h0, busy0}, {32'h0, (i < 15)});
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 4'(i), 4'h0, 32'h0);
            expect_eq("post_sweep_read", {24'h0, rdv0, dout0}, {24'h0, 9'h100});
        end

        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].addr, 4'hF, tbl[i].din);
            expect_eq($sformatf("tbl[%0d]", i), {22'h0, busy0, rdv0, drop0, dout0},
                      {22'h0, tbl[i].e_busy, tbl[i].e_valid, tbl[i].e_drop, tbl[i].e_dout});
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
            expect_eq("clr_sweep_busy", {32'h0, busy0}, {32'h0, (i < 14)});
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'h0, 32'h0);
        expect_eq("after_clr_addr1", {24'h0, rdv0, dout0}, {24'h0, 9'h100});

        // Byte lanes on the 32-bit instance.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'hF, 32'h1122_3344);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'h5, 32'hAABB_CCDD);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        expect_eq("byte_lanes_32", {rdv1, dout1}, {1'b1, 32'h11BB_33DD});
        expect_eq("byte_lanes_8", {24'h0, rdv0, dout0}, {24'h0, 1'b0, 8'hDD});

        // Read-during-write: new data at 8 bits, old data at 32 bits.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'hF, 32'hBB);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'hF, 32'hCC);
        expect_eq("rdw_write_first", {24'h0, rdv0, dout0}, {24'h0, 1'b1, 8'hCC});
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        expect_eq("rdw_read_first", {rdv1, dout1}, {1'b1, 32'h0000_00BB});

        // Reset lands while a 2-cycle read is in flight.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        expect_eq("mid_read_reset", {rdv1, dout1}, {1'b0, 32'h0});
        expect_eq("mid_read_reset_busy", {31'h0, busy1, busy0}, {31'h0, 2'b11});
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
            expect_eq("restart_sweep", {31'h0, busy1, rdv1}, {31'h0, (i < 11), 1'b0});
        end

        // Out-of-range read on the 12-word instance.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 4'h0, 32'h0);
        expect_eq("oor_drop", {32'h0, drop1}, {32'h0, 1'b1});
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        expect_eq("oor_read_zero", {rdv1, dout1}, {1'b1, 32'h0});

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 50),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
